// File: rtl/debounce_array_if.sv
// Button bus for debounce_array: raw button inputs in, debounced levels and strobes out.
// The master side drives btn_in; the debouncer sits on the slave side.
interface debounce_array_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] btn_in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] press_pulse;
   logic [CHANNELS-1:0] release_pulse;
   logic [CHANNELS-1:0] toggle;
   logic                any_pressed;

   modport master (
      output btn_in,
      input  level,
      input  press_pulse,
      input  release_pulse,
      input  toggle,
      input  any_pressed
   );

   modport slave (
      input  btn_in,
      output level,
      output press_pulse,
      output release_pulse,
      output toggle,
      output any_pressed
   );
endinterface

// File: rtl/debounce_array.sv
// Multi-channel push-button debouncer with press/release strobes and per-channel toggle.
// Optional auto-repeat of press_pulse while held is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_array #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_COUNT  = 131072,
   parameter int CNT_WIDTH     = 18,
   parameter int ACTIVE_LOW    = 1,
   parameter int REPEAT_DELAY  = 16777216,
   parameter int REPEAT_PERIOD = 4194304
) (
   input logic            clock,
   input logic            reset,
   debounce_array_if.slave bus
);

   localparam logic [CHANNELS-1:0]  IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(STABLE_COUNT - 1);

   if ((64'(STABLE_COUNT) < 64'd2) ||
       (64'(STABLE_COUNT) > ((64'd1 << CNT_WIDTH) - 64'd1))) begin : g_bad_stable_count
      $error("debounce_array: STABLE_COUNT must lie in 2 .. 2**CNT_WIDTH-1");
   end

   logic [CHANNELS-1:0]  sync1;
   logic [CHANNELS-1:0]  sync2;
   logic [CHANNELS-1:0]  raw_active;
   logic [CHANNELS-1:0]  level_q;
   logic [CHANNELS-1:0]  accept;
   logic [CHANNELS-1:0]  press_evt;
   logic [CHANNELS-1:0]  release_evt;
   logic [CHANNELS-1:0]  repeat_evt;
   logic [CHANNELS-1:0]  press_q;
   logic [CHANNELS-1:0]  release_q;
   logic [CHANNELS-1:0]  toggle_q;
   logic                 any_q;
   logic [CNT_WIDTH-1:0] stable_cnt [CHANNELS];

   // Two-flop synchroniser; reset parks it at the idle level so nothing looks pressed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= IDLE_LEVEL;
         sync2 <= IDLE_LEVEL;
      end else begin
         sync1 <= bus.btn_in;
         sync2 <= sync1;
      end
   end

   assign raw_active = sync2 ^ IDLE_LEVEL;

   // A channel flips once its disagreeing input has been seen for STABLE_COUNT edges.
   always_comb begin
      accept = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         accept[i] = (raw_active[i] != level_q[i]) && (stable_cnt[i] == LAST_COUNT);
      end
      press_evt   = accept & raw_active;
      release_evt = accept & ~raw_active;
   end

   // Any agreement (a bounce back) restarts the count, so only an unbroken run is accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            stable_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if ((raw_active[i] == level_q[i]) || accept[i]) begin
               stable_cnt[i] <= '0;
            end else begin
               stable_cnt[i] <= stable_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int HOLD_WIDTH = $clog2(REPEAT_DELAY + 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_FIRE   = HOLD_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_RELOAD = HOLD_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

   if ((REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
      $error("debounce_array: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
   end

   logic [HOLD_WIDTH-1:0] hold_cnt [CHANNELS];

   always_comb begin
      repeat_evt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         repeat_evt[i] = level_q[i] && !accept[i] && (hold_cnt[i] == HOLD_FIRE);
      end
   end

   // After a repeat the counter is rewound so the next one lands REPEAT_PERIOD edges later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!level_q[i] || accept[i]) begin
               hold_cnt[i] <= '0;
            end else if (repeat_evt[i]) begin
               hold_cnt[i] <= HOLD_RELOAD;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + HOLD_WIDTH'(1);
            end
         end
      end
   end
`else
   assign repeat_evt = '0;
`endif

   // Strobes and toggle are registered alongside level, so they appear the cycle after acceptance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         toggle_q  <= '0;
         any_q     <= 1'b0;
      end else begin
         level_q   <= level_q ^ accept;
         press_q   <= press_evt | repeat_evt;
         release_q <= release_evt;
         toggle_q  <= toggle_q ^ press_evt;
         any_q     <= |level_q;
      end
   end

   assign bus.level         = level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.toggle        = toggle_q;
   assign bus.any_pressed   = any_q;

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent push-button channels.
REQ-002 SHALL have parameter STABLE_COUNT, default 131072: consecutive cycles a new input level must persist before acceptance; legal range 2..2^CNT_WIDTH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 18: width of each channel's stability counter.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means btn_in is pressed when 0; 0 means pressed when 1.
REQ-005 SHALL have parameters REPEAT_DELAY, default 16777216, and REPEAT_PERIOD, default 4194304: auto-repeat timing in cycles, used only under DEBOUNCE_REPEAT_EN.
REQ-006 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port btn_in, input, CHANNELS, raw asynchronous button inputs.
REQ-009 SHALL have port level, output, CHANNELS, debounced pressed state, 1 = pressed.
REQ-010 SHALL have port press_pulse, output, CHANNELS, one-cycle strobe per accepted press (and per repeat).
REQ-011 SHALL have port release_pulse, output, CHANNELS, one-cycle strobe per accepted release.
REQ-012 SHALL have port toggle, output, CHANNELS, state flipped on every accepted press.
REQ-013 SHALL have port any_pressed, output, 1, OR of all level bits, registered.

Function
REQ-014 Each btn_in bit SHALL pass through a two-flop synchroniser; raw_active = sync2 XOR ACTIVE_LOW.
REQ-015 Per channel, when raw_active differs from level the counter SHALL increment; when equal the counter SHALL clear to 0 on that edge (bounce restarts the count).
REQ-016 When the counter reaches STABLE_COUNT-1 while still disagreeing, on that edge level SHALL take raw_active and the counter SHALL clear to 0.
REQ-017 Latency: new btn_in value first sampled at edge N and held SHALL change level at edge N+STABLE_COUNT+1, not earlier or later.
REQ-018 An input excursion lasting fewer than STABLE_COUNT synchronised cycles SHALL produce no change on any output.
REQ-019 press_pulse/release_pulse SHALL be registered, high for exactly the one cycle following the edge on which level rises/falls.
REQ-020 toggle SHALL invert on the same edge press_pulse is set by a genuine press; repeat pulses SHALL NOT flip toggle.
REQ-021 any_pressed SHALL equal OR(level) delayed by one cycle.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-023 Counters SHALL never wrap; reaching STABLE_COUNT-1 always resolves before overflow.

Reset
REQ-024 Reset asserted SHALL immediately (asynchronously) force level, press_pulse, release_pulse, toggle, any_pressed to 0, counters to 0, synchroniser flops to the inactive level (ACTIVE_LOW ? 1 : 0).
REQ-025 A button held pressed across reset release SHALL be accepted as a new press STABLE_COUNT+1 edges after the first post-reset edge.
REQ-026 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted for it.

Configuration
REQ-027 Macro DEBOUNCE_REPEAT_EN defined: while level stays 1, a per-channel hold counter SHALL issue additional press_pulse strobes REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles; release or reset SHALL clear the hold counter.
REQ-028 Macro DEBOUNCE_REPEAT_EN undefined: no hold counter logic SHALL exist; exactly one press_pulse per accepted press; REPEAT_DELAY/REPEAT_PERIOD ignored.

Verification (CHANNELS=4, STABLE_COUNT=8, ACTIVE_LOW=1)
REQ-029 Clean press: btn_in[0]=0 from edge 10, held 30 cycles -> level[0] rises at edge 19, press_pulse[0] high one cycle, toggle[0]=1, any_pressed=1 at edge 20.
REQ-030 Bounce: btn_in[0] low 5 cycles, high 1, low 20 -> no output change during bounce; level[0] rises 9 edges after final low first sampled.
REQ-031 Short glitch: btn_in[2] low 7 cycles then high -> level, pulses, toggle on channel 2 stay 0.
REQ-032 Simultaneous: btn_in[1] and btn_in[3] fall on same edge, later released together -> press_pulse=4'b1010 in one cycle, release_pulse=4'b1010 in one cycle.
REQ-033 Reset mid-count: reset asserted when counter[0]=5 -> all outputs 0 without waiting for a clock edge; after deassert with input held low, level[0] rises 9 edges later.
REQ-034 Repeat (macro defined, REPEAT_DELAY=16, REPEAT_PERIOD=4), hold 40 cycles past acceptance -> press_pulse at acceptance, +16, +20, +24, ..., toggle flips once; macro undefined -> single press_pulse.
